ex_lsu: RTL and testbench

Execute-stage load/store unit, directly upstream of the memory stage. It registers the ID/EX payload under the pipeline stall protocol and computes the effective address. It then drives the data-SRAM request and produces the EX→MEM bus, the byte-lane select and the load-type bus that the memory stage consumes one cycle later. It also raises the load-use stall request.

---
 rtl/ex_lsu_pkg.sv | 40 ++++
 rtl/ex_lsu_lane_gen.sv | 42 ++++
 rtl/ex_lsu.sv | 122 ++++++++++++
 tb/tb_ex_lsu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_lsu_pkg : bus widths, stall encoding and payload layout for ex_lsu |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package ex_lsu_pkg;

  localparam int ID_TO_LSU_WD = 155;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD  = 38;
  localparam int LOAD_BUS_WD  = 5;
  localparam int STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] base;
    logic [15:0] offset;
    logic [31:0] store_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } id_to_lsu_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_lsu_lane_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_lane_gen : byte-lane select, write enables and replicated wdata  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module lsu_lane_gen
  import ex_lsu_pkg::*;
(
  input  logic        mem_en_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [1:0]  size_i,
  input  logic        we_i,
  input  logic [31:0] store_data_i,
  output logic [3:0]  sel_o,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    sel_o = 4'b0000;
    if (mem_en_i) begin
      case (size_i)
        MEM_SZ_B: sel_o = 4'b0001 << ea_lo_i;
        MEM_SZ_H: sel_o = ea_lo_i[1] ? 4'b1100 : 4'b0011;
        MEM_SZ_W: sel_o = 4'b1111;
        default:  sel_o = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (size_i)
      MEM_SZ_B: wdata_o = {4{store_data_i[7:0]}};
      MEM_SZ_H: wdata_o = {2{store_data_i[15:0]}};
      default:  wdata_o = store_data_i;
    endcase
  end

  assign wen_o = we_i ? sel_o : 4'b0000;

endmodule
`default_nettype wire

// File: rtl/ex_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_lsu : EX-stage load/store unit; optional LSU_ALIGN_CHECK_EN       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ex_lsu
  import ex_lsu_pkg::*;
#(
  parameter int STALL_IDX = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_LSU_WD-1:0] id_to_lsu_bus,
  input  logic [1:0]              id_rs_re,
  input  logic [4:0]              id_rs_addr,
  input  logic [4:0]              id_rt_addr,
`ifdef LSU_ALIGN_CHECK_EN
  output logic                    excp_adel,
  output logic                    excp_ades,
  output logic [31:0]             excp_badvaddr,
`endif
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic [3:0]              data_ram_sel,
  output logic [LOAD_BUS_WD-1:0]  ex_load_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    stallreq_load
);

  id_to_lsu_t r_q;
  id_to_lsu_t r_d;

  // EX stopped while MEM drains: inject a bubble rather than hold
  always_comb begin
    r_d = r_q;
    if (stall[STALL_IDX] == STOP && stall[STALL_IDX+1] == NO_STOP)
      r_d = '0;
    else if (stall[STALL_IDX] == NO_STOP)
      r_d = id_to_lsu_t'(id_to_lsu_bus);
  end

  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= r_d;
  end

  logic w_unused_stall;
  assign w_unused_stall = ^stall;

  logic [31:0] w_ea;
  logic [3:0]  w_sel;
  logic [3:0]  w_lane_wen;
  logic [31:0] w_wdata;
  logic        w_load;
  logic        w_fault;
  logic        w_rf_we;
  logic [31:0] w_result;
  logic [4:0]  w_load_dec;

  assign w_ea = r_q.base + sext16(r_q.offset);

  lsu_lane_gen u_lane_gen (
    .mem_en_i     (r_q.mem_en),
    .ea_lo_i      (w_ea[1:0]),
    .size_i       (r_q.mem_size),
    .we_i         (r_q.mem_we),
    .store_data_i (r_q.store_data),
    .sel_o        (w_sel),
    .wen_o        (w_lane_wen),
    .wdata_o      (w_wdata)
  );

  assign w_load = r_q.mem_en & ~r_q.mem_we;

`ifdef LSU_ALIGN_CHECK_EN
  assign w_fault = r_q.mem_en &
                   (((r_q.mem_size == MEM_SZ_H) & w_ea[0]) |
                    ((r_q.mem_size == MEM_SZ_W) & (w_ea[1:0] != 2'b00)));
  assign excp_adel     = w_fault & ~r_q.mem_we;
  assign excp_ades     = w_fault &  r_q.mem_we;
  assign excp_badvaddr = w_ea;
`else
  assign w_fault = 1'b0;
`endif

  // {lb, lbu, lh, lhu, lw}
  always_comb begin
    w_load_dec = 5'b00000;
    if (w_load) begin
      case (r_q.mem_size)
        MEM_SZ_B: w_load_dec = r_q.mem_unsigned ? 5'b01000 : 5'b10000;
        MEM_SZ_H: w_load_dec = r_q.mem_unsigned ? 5'b00010 : 5'b00100;
        MEM_SZ_W: w_load_dec = 5'b00001;
        default:  w_load_dec = 5'b00000;
      endcase
    end
  end

  assign w_rf_we  = r_q.rf_we & ~w_fault;
  assign w_result = r_q.mem_en ? w_ea : r_q.alu_result;

  assign data_sram_en    = r_q.mem_en & ~w_fault;
  assign data_sram_wen   = w_lane_wen & {4{~w_fault}};
  assign data_sram_addr  = w_ea;
  assign data_sram_wdata = w_wdata;
  assign data_ram_sel    = w_sel;
  assign ex_load_bus     = w_fault ? 5'b00000 : w_load_dec;

  assign ex_to_mem_bus = {r_q.pc, data_sram_en, data_sram_wen, w_load,
                          w_rf_we, r_q.rf_waddr, w_result};
  assign ex_to_rf_bus  = {w_rf_we, r_q.rf_waddr, w_result};

  assign stallreq_load = w_load & w_rf_we & (r_q.rf_waddr != 5'd0) &
                         ((id_rs_re[0] & (id_rs_addr == r_q.rf_waddr)) |
                          (id_rs_re[1] & (id_rt_addr == r_q.rf_waddr)));

endmodule
`default_nettype wire

// File: tb/tb_ex_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ex_lsu : directed scoreboard bench for ex_lsu                      |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_ex_lsu;
  import ex_lsu_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [STALL_WD-1:0]     stall;
  logic [ID_TO_LSU_WD-1:0] id_to_lsu_bus;
  logic [1:0]              id_rs_re;
  logic [4:0]              id_rs_addr;
  logic [4:0]              id_rt_addr;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic [3:0]              data_ram_sel;
  logic [LOAD_BUS_WD-1:0]  ex_load_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
  logic                    stallreq_load;
`ifdef LSU_ALIGN_CHECK_EN
  logic                    excp_adel;
  logic                    excp_ades;
  logic [31:0]             excp_badvaddr;
`endif

  ex_lsu #(.STALL_IDX(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_lsu_bus   (id_to_lsu_bus),
    .id_rs_re        (id_rs_re),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
`ifdef LSU_ALIGN_CHECK_EN
    .excp_adel       (excp_adel),
    .excp_ades       (excp_ades),
    .excp_badvaddr   (excp_badvaddr),
`endif
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_ram_sel    (data_ram_sel),
    .ex_load_bus     (ex_load_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .stallreq_load   (stallreq_load)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [4:0]  lbus;
    logic [75:0] mbus;
    logic [37:0] rbus;
    logic        sreq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stepn  = 0;

  function automatic logic [154:0] mk(
      input logic [31:0] pc, input logic en, input logic we, input logic [1:0] sz,
      input logic uns, input logic [31:0] base, input logic [15:0] off,
      input logic [31:0] sd, input logic rfwe, input logic [4:0] wa,
      input logic [31:0] alu);
    id_to_lsu_t p;
    p.pc = pc; p.mem_en = en; p.mem_we = we; p.mem_size = sz; p.mem_unsigned = uns;
    p.base = base; p.offset = off; p.store_data = sd; p.rf_we = rfwe;
    p.rf_waddr = wa; p.alu_result = alu;
    return p;
  endfunction

  task automatic push(
      input logic en, input logic [3:0] wen, input logic [31:0] addr,
      input logic [31:0] wdata, input logic [3:0] sel, input logic [4:0] lbus,
      input logic [31:0] pc, input logic selres, input logic rfwe,
      input logic [4:0] wa, input logic [31:0] res, input logic sreq);
    exp_t e;
    e.en = en; e.wen = wen; e.addr = addr; e.wdata = wdata; e.sel = sel;
    e.lbus = lbus; e.sreq = sreq;
    e.mbus = {pc, en, wen, selres, rfwe, wa, res};
    e.rbus = {rfwe, wa, res};
    sb.push_back(e);
  endtask

  task automatic push_zero();
    push(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 5'h0, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL s%0d_%s got %h want %h", stepn, tag, obs, want);
    end
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    stepn++;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL s%0d_sb_underflow got 0 want 1", stepn);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sram_en",  {75'd0, data_sram_en},    {75'd0, e.en});
      chk("wen",      {72'd0, data_sram_wen},   {72'd0, e.wen});
      chk("addr",     {44'd0, data_sram_addr},  {44'd0, e.addr});
      chk("wdata",    {44'd0, data_sram_wdata}, {44'd0, e.wdata});
      chk("sel",      {72'd0, data_ram_sel},    {72'd0, e.sel});
      chk("load_bus", {71'd0, ex_load_bus},     {71'd0, e.lbus});
      chk("mem_bus",  ex_to_mem_bus,            e.mbus);
      chk("rf_bus",   {38'd0, ex_to_rf_bus},    {38'd0, e.rbus});
      chk("stallreq", {75'd0, stallreq_load},   {75'd0, e.sreq});
    end
  endtask

  task automatic drive(input logic [154:0] p, input logic [5:0] st,
                       input logic [1:0] re, input logic [4:0] rs, input logic [4:0] rt);
    id_to_lsu_bus = p; stall = st; id_rs_re = re; id_rs_addr = rs; id_rt_addr = rt;
  endtask

  logic [154:0] p_sb, p_sw;

  initial begin
    rst = 1'b1;
    drive('0, 6'b0, 2'b00, 5'd0, 5'd0);
    push_zero();
    tick_check();
    rst = 1'b0;

    // sb to 0x1003
    p_sb = mk(32'h100, 1, 1, MEM_SZ_B, 0, 32'h1000, 16'h0003, 32'h000000AB, 0, 5'd0, 32'h0);
    drive(p_sb, 6'b0, 2'b00, 5'd0, 5'd0);
    push(1, 4'b1000, 32'h1003, 32'hABABABAB, 4'b1000, 5'b00000, 32'h100, 0, 0, 5'd0, 32'h1003, 0);
    tick_check();

    // lh with negative offset
    drive(mk(32'h104, 1, 0, MEM_SZ_H, 0, 32'h1004, 16'hFFFE, 32'h12345678, 1, 5'd3, 32'h0),
          6'b0, 2'b00, 5'd0, 5'd0);
    push(1, 4'b0000, 32'h1002, 32'h56785678, 4'b1100, 5'b00100, 32'h104, 1, 1, 5'd3, 32'h1002, 0);
    tick_check();

    // lbu to r7, ID reads rt=7
    drive(mk(32'h108, 1, 0, MEM_SZ_B, 1, 32'h2000, 16'h0001, 32'h0, 1, 5'd7, 32'h0),
          6'b0, 2'b10, 5'd0, 5'd7);
    push(1, 4'b0000, 32'h2001, 32'h0, 4'b0010, 5'b01000, 32'h108, 1, 1, 5'd7, 32'h2001, 1);
    tick_check();

    // sh upper half
    drive(mk(32'h10C, 1, 1, MEM_SZ_H, 0, 32'h3000, 16'h0006, 32'h0000BEEF, 0, 5'd0, 32'h0),
          6'b0, 2'b00, 5'd0, 5'd0);
    push(1, 4'b1100, 32'h3006, 32'hBEEFBEEF, 4'b1100, 5'b00000, 32'h10C, 0, 0, 5'd0, 32'h3006, 0);
    tick_check();

    // sw with address wrap
    p_sw = mk(32'h110, 1, 1, MEM_SZ_W, 0, 32'hFFFFFFF8, 16'h0010, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    drive(p_sw, 6'b0, 2'b00, 5'd0, 5'd0);
    push(1, 4'b1111, 32'h8, 32'hDEADBEEF, 4'b1111, 5'b00000, 32'h110, 0, 0, 5'd0, 32'h8, 0);
    tick_check();

    // non-memory op writing r9, ID reads r9: no load, no stall
    drive(mk(32'h114, 0, 0, MEM_SZ_B, 0, 32'h1234, 16'h0010, 32'h0, 1, 5'd9, 32'h55AA),
          6'b0, 2'b01, 5'd9, 5'd0);
    push(0, 4'b0000, 32'h1244, 32'h0, 4'b0000, 5'b00000, 32'h114, 0, 1, 5'd9, 32'h55AA, 0);
    tick_check();

    // lhu low half
    drive(mk(32'h118, 1, 0, MEM_SZ_H, 1, 32'h40, 16'h0000, 32'h0, 1, 5'd2, 32'h0),
          6'b0, 2'b00, 5'd0, 5'd0);
    push(1, 4'b0000, 32'h40, 32'h0, 4'b0011, 5'b00010, 32'h118, 1, 1, 5'd2, 32'h40, 0);
    tick_check();

    // lb to r0: dependency on r0 never stalls
    drive(mk(32'h11C, 1, 0, MEM_SZ_B, 0, 32'h50, 16'hFFFF, 32'h0, 1, 5'd0, 32'h0),
          6'b0, 2'b01, 5'd0, 5'd0);
    push(1, 4'b0000, 32'h4F, 32'h0, 4'b1000, 5'b10000, 32'h11C, 1, 1, 5'd0, 32'h4F, 0);
    tick_check();

    // load-use: lw r5 then ID reads rs=5
    drive(mk(32'h200, 1, 0, MEM_SZ_W, 0, 32'h2000, 16'h0004, 32'h0, 1, 5'd5, 32'h0),
          6'b0, 2'b01, 5'd5, 5'd0);
    push(1, 4'b0000, 32'h2004, 32'h0, 4'b1111, 5'b00001, 32'h200, 1, 1, 5'd5, 32'h2004, 1);
    tick_check();

    // EX stop, MEM go: bubble
    drive(p_sb, 6'b000100, 2'b01, 5'd5, 5'd0);
    push_zero();
    tick_check();

    // hold for three cycles with EX and MEM stopped
    drive(mk(32'h204, 1, 0, MEM_SZ_W, 0, 32'h2000, 16'h0008, 32'h0, 1, 5'd6, 32'h0),
          6'b0, 2'b00, 5'd0, 5'd0);
    push(1, 4'b0000, 32'h2008, 32'h0, 4'b1111, 5'b00001, 32'h204, 1, 1, 5'd6, 32'h2008, 0);
    tick_check();
    drive(p_sw, 6'b001100, 2'b00, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      push(1, 4'b0000, 32'h2008, 32'h0, 4'b1111, 5'b00001, 32'h204, 1, 1, 5'd6, 32'h2008, 0);
      tick_check();
    end
    drive(p_sw, 6'b0, 2'b00, 5'd0, 5'd0);
    push(1, 4'b1111, 32'h8, 32'hDEADBEEF, 4'b1111, 5'b00000, 32'h110, 0, 0, 5'd0, 32'h8, 0);
    tick_check();

    // misaligned lw at 0x2002, ID reads rs=4
    drive(mk(32'h208, 1, 0, MEM_SZ_W, 0, 32'h2000, 16'h0002, 32'h0, 1, 5'd4, 32'h0),
          6'b0, 2'b01, 5'd4, 5'd0);
`ifdef LSU_ALIGN_CHECK_EN
    push(0, 4'b0000, 32'h2002, 32'h0, 4'b1111, 5'b00000, 32'h208, 1, 0, 5'd4, 32'h2002, 0);
    tick_check();
    chk("excp_adel", {75'd0, excp_adel},      76'd1);
    chk("excp_ades", {75'd0, excp_ades},      76'd0);
    chk("badvaddr",  {44'd0, excp_badvaddr},  {44'd0, 32'h2002});
`else
    push(1, 4'b0000, 32'h2002, 32'h0, 4'b1111, 5'b00001, 32'h208, 1, 1, 5'd4, 32'h2002, 1);
    tick_check();
`endif

    // store, then reset while it sits in EX
    drive(mk(32'h20C, 1, 1, MEM_SZ_W, 0, 32'h30, 16'h0000, 32'h11223344, 0, 5'd0, 32'h0),
          6'b0, 2'b00, 5'd0, 5'd0);
    push(1, 4'b1111, 32'h30, 32'h11223344, 4'b1111, 5'b00000, 32'h20C, 0, 0, 5'd0, 32'h30, 0);
    tick_check();
    rst = 1'b1;
    push_zero();
    tick_check();
    rst = 1'b0;

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover got %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
